// File: rtl/prime_pkg.sv
// Shared defaults and entry type for the prime stream filter.
package prime_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_IDX_W  = 16;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_CNT_W  = 32;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] n;
        logic [DEF_IDX_W-1:0]  idx;
    } prime_entry_t;

endpackage

// File: rtl/prime_fifo.sv
// Synchronous first-word-fall-through FIFO; head is 0 while empty.
// Pushes on full and pops on empty are ignored.
module prime_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/prime_stream_filter.sv
// Drops composites, buffers primes with their input sequence index, replays them in order.
// Define PRIME_FILTER_STATS_EN to build the saturating statistics counters.
module prime_stream_filter
    import prime_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_is_prime,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  cnt_total,
    output logic [CNT_W-1:0]  cnt_prime,
    output logic [CNT_W-1:0]  cnt_drop
);

    typedef struct packed {
        logic [DATA_W-1:0] n;
        logic [IDX_W-1:0]  idx;
    } entry_t;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    logic             accept, push, pop;
    logic [IDX_W-1:0] seq_idx_q;
    entry_t           push_entry, head_entry;

    // No pass-through when full: a pop in the same cycle does not free a slot early.
    assign in_ready   = !full;
    assign out_valid  = !empty;
    assign accept     = in_valid && in_ready;
    assign push       = accept && in_is_prime;
    assign pop        = out_valid && out_ready;
    assign push_entry = '{n: in_data, idx: seq_idx_q};
    assign out_data   = head_entry.n;
    assign out_idx    = head_entry.idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      seq_idx_q <= '0;
        else if (accept) seq_idx_q <= seq_idx_q + IDX_ONE;
    end

    prime_fifo #(
        .WIDTH (DATA_W + IDX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .full      (full),
        .empty     (empty)
    );

`ifdef PRIME_FILTER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_total_q, cnt_prime_q, cnt_drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_total_q <= '0;
            cnt_prime_q <= '0;
            cnt_drop_q  <= '0;
        end else if (accept) begin
            if (cnt_total_q != CNT_MAX) cnt_total_q <= cnt_total_q + CNT_ONE;
            if (in_is_prime && cnt_prime_q != CNT_MAX) cnt_prime_q <= cnt_prime_q + CNT_ONE;
            if (!in_is_prime && cnt_drop_q != CNT_MAX) cnt_drop_q <= cnt_drop_q + CNT_ONE;
        end
    end

    assign cnt_total = cnt_total_q;
    assign cnt_prime = cnt_prime_q;
    assign cnt_drop  = cnt_drop_q;
`else
    assign cnt_total = '0;
    assign cnt_prime = '0;
    assign cnt_drop  = '0;
`endif

endmodule
